// File: rtl/mips_uart_receiver_pkg.sv
// ---------------------------------------------------------------------------
// mips_uart_receiver_pkg
//  Shared definitions for the MIPS debug-unit UART path: receiver FSM state
//  encoding, oversampling ratio, and the debug command byte values the host
//  tooling sends over the serial line.
// ---------------------------------------------------------------------------
package mips_uart_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Oversample ticks per bit period.
  localparam int OVERSAMPLE = 16;

  // Tick count from the start edge to the middle of the start bit.
  localparam int MID_TICK = 7;

  // Debug command bytes.
  localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_LOAD = 8'h6C;  // 'l'
  localparam logic [7:0] CMD_NEXT = 8'h6E;  // 'n'

endpackage

// File: rtl/mips_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// mips_uart_baud_gen
//  Free-running oversample tick generator. The counter runs 0..CLK_DIV-1 and
//  o_tick is high for the single clk in which it sits at CLK_DIV-1.
//  Shared by the UART receiver and transmitter.
// Ports:
//  clk     in   system clock
//  reset   in   asynchronous, active-high
//  o_tick  out  1-clk pulse every CLK_DIV clks
// ---------------------------------------------------------------------------
module mips_uart_baud_gen #(
  parameter int CLK_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/mips_uart_receiver.sv
// ---------------------------------------------------------------------------
// mips_uart_receiver
//  8N1 UART receiver with 16x oversampling for the MIPS debug unit.
//  Bytes are presented with a level ready flag; the consumer drops the
//  flags by holding i_rx_reset. Framing errors and overruns are flagged.
// Ports:
//  clk          in   system clock
//  reset        in   asynchronous, active-high
//  i_rx         in   serial line, idle high, asynchronous to clk
//  i_rx_reset   in   level clear of o_rx_ready / o_frame_err / o_overrun
//  o_rx_ready   out  byte available in o_rx_data
//  o_rx_data    out  last good byte received
//  o_frame_err  out  last frame had stop bit = 0
//  o_overrun    out  good byte completed while o_rx_ready was already 1
// ---------------------------------------------------------------------------
module mips_uart_receiver
  import mips_uart_receiver_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 163
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_rx_reset,
  output logic                 o_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  // START acts on the tick that brings tc to MID_TICK, so the start bit is
  // checked MID_TICK ticks after the edge and every later sample lands a
  // whole bit period after that.
  localparam logic [TCW-1:0] TC_MID  = TCW'(MID_TICK - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 rx_prev_q;

  rx_state_e            state_q, state_d;
  logic [TCW-1:0]       tc_q, tc_d;
  logic [BCW-1:0]       bc_q, bc_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  mips_uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      tc_q      <= '0;
      bc_q      <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      tc_q      <= tc_d;
      bc_q      <= bc_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bc_d    = bc_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Consumer clear; frame events below override it in the same cycle.
    if (i_rx_reset) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Edge-triggered so a held-low (break) line cannot restart a frame.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          tc_d    = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tc_q == TC_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              tc_d    = '0;
              bc_d    = '0;
              state_d = ST_DATA;
            end
          end else begin
            tc_d = tc_q + TCW'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tc_q == TC_LAST) begin
            tc_d    = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bc_q == BC_LAST) begin
              state_d = ST_STOP;
            end else begin
              bc_d = bc_q + BCW'(1);
            end
          end else begin
            tc_d = tc_q + TCW'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tc_q == TC_LAST) begin
            tc_d    = '0;
            state_d = ST_IDLE;
            if (rx_s) begin
              data_d  = shreg_q;
              ready_d = 1'b1;
              ferr_d  = 1'b0;
              // A simultaneous clear counts as consuming the previous byte.
              ovr_d   = i_rx_reset ? 1'b0 : (ovr_q | ready_q);
            end else begin
              ferr_d  = 1'b1;
            end
          end else begin
            tc_d = tc_q + TCW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_rx_ready  = ready_q;
  assign o_rx_data   = data_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule
